// File: rtl/eq_band_scheduler.sv
// eq_band_scheduler
// Time-shares one 31-tap FIR engine across up to four coefficient sets
// (lpf, hpf, bpf1, bpf2). Each enabled band's result is gain-weighted and
// summed into a saturated 8-bit output, which makes a 4-band equalizer.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   ready, audio_in     new-sample strobe and signed 8-bit sample
//   band_en             band enable mask (bit0 lpf .. bit3 bpf2)
//   band_gain           four 3-bit unsigned gains, band0 in [2:0]
//   fir_ready/sel/x     start pulse, coefficient select, latched sample to FIR
//   fir_done, fir_y     FIR result strobe and signed 18-bit result
//   audio_out, done     equalized sample and its one-cycle update pulse
//   busy                high whenever the sequencer is not idle
//   overrun             sticky: sample arrived while busy and was dropped
//   timeout_err         sticky: a band was abandoned for lack of fir_done
module eq_band_scheduler #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned GAIN_SHIFT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic [7:0]  audio_in,
    input  logic [3:0]  band_en,
    input  logic [11:0] band_gain,
    output logic        fir_ready,
    output logic [1:0]  fir_sel,
    output logic [7:0]  fir_x,
    input  logic        fir_done,
    input  logic [17:0] fir_y,
    output logic [7:0]  audio_out,
    output logic        done,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int unsigned ACC_W   = 14;
    localparam int unsigned PROD_W  = 12;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state, nxt_state;

    logic [3:0]               mask, mask_d;
    logic [11:0]              gains, gains_d;
    logic signed [ACC_W-1:0]  acc, acc_d;
    logic [TIMER_W-1:0]       timer, timer_d;
    logic [1:0]               sel_d;
    logic [7:0]               fir_x_d, audio_out_d;
    logic                     fir_ready_d, done_d, busy_d;
    logic                     overrun_d, timeout_err_d;

    logic [2:0]               cur_gain;
    logic signed [PROD_W-1:0] y_ext, g_ext, prod, contrib;
    logic [3:0]               higher;
    logic                     timed_out;

    // Low bits of the FIR result are below the output resolution.
    logic unused_low_bits;
    assign unused_low_bits = ^fir_y[9:0];

    // Index of the lowest set bit (0 when none set).
    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        lowest_bit = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_bit = 2'(i);
        end
    endfunction

    // Gain for the band currently in flight.
    always_comb begin
        cur_gain = gains[2:0];
        case (fir_sel)
            2'd0: cur_gain = gains[2:0];
            2'd1: cur_gain = gains[5:3];
            2'd2: cur_gain = gains[8:6];
            2'd3: cur_gain = gains[11:9];
            default: cur_gain = gains[2:0];
        endcase
    end

    // Band contribution: upper result byte times gain, then arithmetic shift.
    always_comb begin
        y_ext   = PROD_W'($signed(fir_y[17:10]));
        g_ext   = PROD_W'($signed({1'b0, cur_gain}));
        prod    = y_ext * g_ext;
        contrib = prod >>> GAIN_SHIFT;
    end

    // Enabled bands strictly above the current one.
    assign higher    = mask & 4'(4'hE << fir_sel);
    assign timed_out = (timer == TIMER_LAST);

    // Next-state and next-register values.
    always_comb begin
        nxt_state     = state;
        mask_d        = mask;
        gains_d       = gains;
        acc_d         = acc;
        timer_d       = timer;
        sel_d         = fir_sel;
        fir_x_d       = fir_x;
        audio_out_d   = audio_out;
        overrun_d     = overrun;
        timeout_err_d = timeout_err;

        case (state)
            IDLE: begin
                if (ready) begin
                    fir_x_d = audio_in;
                    mask_d  = band_en;
                    gains_d = band_gain;
                    acc_d   = '0;
                    if (band_en != 4'd0) begin
                        sel_d     = lowest_bit(band_en);
                        nxt_state = ISSUE;
                    end else begin
                        nxt_state = FINISH;
                    end
                end
            end
            ISSUE: begin
                timer_d   = '0;
                nxt_state = WAIT;
            end
            WAIT: begin
                timer_d = TIMER_W'(timer + 1'b1);
                if (fir_done) begin
                    acc_d = acc + ACC_W'(contrib);
                end
                if (fir_done || timed_out) begin
                    // fir_done on the last timer cycle still counts as a result.
                    if (!fir_done) timeout_err_d = 1'b1;
                    if (higher != 4'd0) begin
                        sel_d     = lowest_bit(higher);
                        nxt_state = ISSUE;
                    end else begin
                        nxt_state = FINISH;
                    end
                end
            end
            FINISH: begin
                if (acc > ACC_W'(127)) begin
                    audio_out_d = 8'sd127;
                end else if (acc < -ACC_W'(128)) begin
                    audio_out_d = 8'h80;
                end else begin
                    audio_out_d = acc[7:0];
                end
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase

        // Samples arriving mid-sequence are dropped.
        if (ready && (state != IDLE)) overrun_d = 1'b1;

        fir_ready_d = (nxt_state == ISSUE);
        busy_d      = (nxt_state != IDLE);
        done_d      = (state == FINISH);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            mask        <= '0;
            gains       <= '0;
            acc         <= '0;
            timer       <= '0;
            fir_sel     <= '0;
            fir_x       <= '0;
            fir_ready   <= 1'b0;
            audio_out   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= nxt_state;
            mask        <= mask_d;
            gains       <= gains_d;
            acc         <= acc_d;
            timer       <= timer_d;
            fir_sel     <= sel_d;
            fir_x       <= fir_x_d;
            fir_ready   <= fir_ready_d;
            audio_out   <= audio_out_d;
            done        <= done_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed bench for eq_band_scheduler with a mock FIR engine that answers
// each fir_ready after a programmable delay with a per-band result.
module tb_eq_band_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic [7:0]  audio_in;
    logic [3:0]  band_en;
    logic [11:0] band_gain;
    logic        fir_ready;
    logic [1:0]  fir_sel;
    logic [7:0]  fir_x;
    logic        fir_done;
    logic [17:0] fir_y;
    logic [7:0]  audio_out;
    logic        done;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Mock FIR configuration and observation log.
    logic [17:0] mock_y [4];
    logic [3:0]  mock_silent;
    int          mock_delay;
    int          sel_log [$];
    int          done_count;

    eq_band_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .ready       (ready),
        .audio_in    (audio_in),
        .band_en     (band_en),
        .band_gain   (band_gain),
        .fir_ready   (fir_ready),
        .fir_sel     (fir_sel),
        .fir_x       (fir_x),
        .fir_done    (fir_done),
        .fir_y       (fir_y),
        .audio_out   (audio_out),
        .done        (done),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] mk(input int upper);
        mk = 18'(upper * 1024);
    endfunction

    function automatic logic [11:0] gset(input int g0, input int g1, input int g2, input int g3);
        gset = {3'(g3), 3'(g2), 3'(g1), 3'(g0)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse ready with the given setup, then count cycles until done (ready cycle = 0).
    task automatic run(input logic [3:0] en, input logic [11:0] g, input logic [7:0] smp,
                       output int n);
        band_en   = en;
        band_gain = g;
        audio_in  = smp;
        ready     = 1'b1;
        tick();
        ready = 1'b0;
        n = 1;
        while (!done && n < 600) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done), 1);
    endtask

    // Mock FIR engine plus fir_sel/done logging, all sampled mid-cycle.
    initial begin
        int          cnt;
        logic [1:0]  msel;
        logic        pend;
        cnt      = 0;
        msel     = 2'd0;
        pend     = 1'b0;
        fir_done = 1'b0;
        fir_y    = '0;
        forever begin
            tick();
            fir_done = 1'b0;
            if (done) done_count++;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    fir_done = 1'b1;
                    fir_y    = mock_y[msel];
                    pend     = 1'b0;
                end
            end
            if (fir_ready) begin
                sel_log.push_back(int'(fir_sel));
                msel = fir_sel;
                pend = !mock_silent[fir_sel];
                cnt  = mock_delay;
            end
        end
    end

    initial begin
        int n;
        reset       = 1'b1;
        ready       = 1'b0;
        audio_in    = '0;
        band_en     = '0;
        band_gain   = '0;
        mock_silent = '0;
        mock_delay  = 10;
        done_count  = 0;
        for (int i = 0; i < 4; i++) mock_y[i] = '0;

        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fir_ready", 32'(fir_ready), 0);
        check("rst_audio_out", 32'(audio_out), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b0;
        tick();

        // Single lpf band, unity gain, result byte 50.
        mock_y[0] = 18'h0C800;
        sel_log.delete();
        band_en   = 4'b0001;
        band_gain = gset(4, 0, 0, 0);
        audio_in  = 8'h5A;
        ready     = 1'b1;
        tick();
        ready = 1'b0;
        check("t1_fir_ready_c1", 32'(fir_ready), 1);
        check("t1_fir_sel_c1", 32'(fir_sel), 0);
        check("t1_fir_x", 32'(fir_x), 32'h5A);
        n = 1;
        while (!done && n < 600) begin
            tick();
            n++;
        end
        check("t1_done_cycle", n, 13);
        check("t1_audio_out", $signed(audio_out), 50);
        tick();
        check("t1_done_pulse", 32'(done), 0);
        check("t1_busy_idle", 32'(busy), 0);

        // All four bands with mixed gains.
        mock_delay = 3;
        mock_y[0] = mk(40);
        mock_y[1] = mk(-20);
        mock_y[2] = mk(10);
        mock_y[3] = mk(30);
        sel_log.delete();
        run(4'b1111, gset(4, 2, 4, 7), 8'h11, n);
        check("t2_audio_out", $signed(audio_out), 92);
        check("t2_sel_count", sel_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < sel_log.size()) check("t2_sel_order", sel_log[i], i);
        end
        tick();

        // Positive and negative saturation.
        mock_y[0] = mk(127);
        mock_y[3] = mk(127);
        run(4'b1001, gset(7, 0, 0, 7), 8'h00, n);
        check("t3_sat_pos", $signed(audio_out), 127);
        tick();
        mock_y[0] = mk(-128);
        mock_y[3] = mk(-128);
        run(4'b1001, gset(7, 0, 0, 7), 8'h00, n);
        check("t3_sat_neg", $signed(audio_out), -128);
        tick();

        // Band 1 never answers: abandoned after timeout, band 2 still issued.
        check("t4_timeout_err_before", 32'(timeout_err), 0);
        mock_silent = 4'b0010;
        mock_y[1]   = mk(100);
        mock_y[2]   = mk(10);
        sel_log.delete();
        run(4'b0110, gset(0, 4, 4, 0), 8'h00, n);
        check("t4_done_cycle", n, 262);
        check("t4_audio_out", $signed(audio_out), 10);
        check("t4_timeout_err", 32'(timeout_err), 1);
        check("t4_sel_count", sel_log.size(), 2);
        if (sel_log.size() == 2) begin
            check("t4_sel_first", sel_log[0], 1);
            check("t4_sel_second", sel_log[1], 2);
        end
        mock_silent = '0;
        tick();

        // Second ready three cycles into a sequence is dropped.
        check("t5_overrun_before", 32'(overrun), 0);
        mock_delay = 10;
        mock_y[0]  = mk(20);
        done_count = 0;
        band_en    = 4'b0001;
        band_gain  = gset(4, 0, 0, 0);
        ready      = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        band_gain = gset(7, 0, 0, 0);
        ready     = 1'b1;
        tick();
        ready = 1'b0;
        n = 4;
        while (!done && n < 600) begin
            tick();
            n++;
        end
        check("t5_done_cycle", n, 13);
        check("t5_audio_out", $signed(audio_out), 20);
        check("t5_overrun", 32'(overrun), 1);
        repeat (30) tick();
        check("t5_done_count", done_count, 1);
        check("t5_busy_after", 32'(busy), 0);

        // Empty mask finishes immediately with zero.
        run(4'b0000, gset(4, 4, 4, 4), 8'h33, n);
        check("t5_empty_done_cycle", n, 2);
        check("t5_empty_audio_out", $signed(audio_out), 0);
        tick();

        // Reset while waiting on the FIR aborts cleanly.
        done_count = 0;
        band_en    = 4'b0001;
        band_gain  = gset(4, 0, 0, 0);
        ready      = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        check("t6_busy_in_wait", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy_after_reset", 32'(busy), 0);
        check("t6_fir_ready_after_reset", 32'(fir_ready), 0);
        check("t6_done_after_reset", 32'(done), 0);
        check("t6_overrun_cleared", 32'(overrun), 0);
        check("t6_timeout_err_cleared", 32'(timeout_err), 0);
        repeat (20) tick();
        check("t6_no_done", done_count, 0);
        mock_y[0] = mk(-60);
        run(4'b0001, gset(2, 0, 0, 0), 8'h00, n);
        check("t6_fresh_done_cycle", n, 13);
        check("t6_fresh_audio_out", $signed(audio_out), -30);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
